// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift_ctrl frame serializer.
package shift_ctrl_pkg;

   localparam int WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : shift_ctrl_pkg

// File: rtl/shift_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer favours the requester not served last.
module shift_ctrl_arb
   import shift_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic update,
   output logic gnt_a,
   output logic gnt_b
);

   // prio_b_q = 1 means B wins a tie; reset leaves A in front.
   logic prio_b_q;
   logic prio_b_d;

   always_comb begin
      gnt_a    = req_a & (~req_b | ~prio_b_q);
      gnt_b    = req_b & (~req_a |  prio_b_q);
      prio_b_d = prio_b_q;
      if (update && (gnt_a || gnt_b)) begin
         prio_b_d = gnt_a;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_b_q <= 1'b0;
      end else begin
         prio_b_q <= prio_b_d;
      end
   end

endmodule : shift_ctrl_arb

// File: rtl/shift_ctrl.sv
// Arbitrated parallel-to-serial frame shifter: grant, WIDTH data bits, one done cycle.
module shift_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   input  logic             dir,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sout,
   output logic             sout_vld,
   output logic             owner,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             dir_q,   dir_d;
   logic             owner_q, owner_d;

   // Grants are only offered in IDLE and are forced low while reset is held.
   logic grant_ok;
   assign grant_ok = (state_q == IDLE) & rst;

   shift_ctrl_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_a  (req_a & grant_ok),
      .req_b  (req_b & grant_ok),
      .update (grant_ok),
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (gnt_a || gnt_b) begin
               shreg_d = gnt_b ? data_b : data_a;
               dir_d   = dir;
               owner_d = gnt_b;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         owner_q <= owner_d;
      end
   end

   // The outgoing bit sits at the end selected by the latched direction.
   assign sout_vld = (state_q == SHIFT);
   assign sout     = sout_vld & (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
   assign busy     = (state_q == SHIFT) | (state_q == DONE);
   assign done     = (state_q == DONE);
   assign owner    = owner_q;

endmodule : shift_ctrl

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: reset, bit order, arbitration and late requests.
module tb_shift_ctrl;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         req_a;
   logic [W-1:0] data_a;
   logic         req_b;
   logic [W-1:0] data_b;
   logic         dir;
   logic         gnt_a;
   logic         gnt_b;
   logic         sout;
   logic         sout_vld;
   logic         owner;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   shift_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_a    (req_a),
      .data_a   (data_a),
      .req_b    (req_b),
      .data_b   (data_b),
      .dir      (dir),
      .gnt_a    (gnt_a),
      .gnt_b    (gnt_b),
      .sout     (sout),
      .sout_vld (sout_vld),
      .owner    (owner),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] outs;
      rst = 1'b0; req_a = 1'b1; data_a = 4'hB; req_b = 1'b0; data_b = '0; dir = 1'b0;
      repeat (3) nxt();
      #1;
      outs = {gnt_a, gnt_b, sout, sout_vld, owner, busy, done};
      checks++;
      if (outs !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 0000000", outs);
      end
      $display("reset: outputs held low under rst=0 with req_a=1");
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt_a, gnt_b} !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_grant got %b expected 10", {gnt_a, gnt_b});
      end
      $display("reset: release, first-cycle grant gnt_a=%b", gnt_a);
      nxt();
      req_a = 1'b0;
      repeat (5) nxt();
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame_end busy got %b expected 0", busy);
      end
   endtask

   task automatic test_msb();
      logic [W-1:0] word;
      word = 4'b1011;
      req_a = 1'b1; data_a = word; dir = 1'b0;
      #1;
      checks++;
      if ({gnt_a, gnt_b, busy} !== 3'b100) begin
         errors++;
         $display("FAIL msb_grant got gnt_a/gnt_b/busy=%b expected 100", {gnt_a, gnt_b, busy});
      end
      nxt();
      req_a = 1'b0; data_a = '0; dir = 1'b1;
      for (int i = 0; i < W; i++) begin
         #1;
         checks++;
         if ({sout_vld, sout, owner, busy, gnt_a} !== {1'b1, word[W-1-i], 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL msb_bit%0d got vld/sout/owner/busy/gnt=%b expected %b", i,
                     {sout_vld, sout, owner, busy, gnt_a}, {1'b1, word[W-1-i], 3'b010});
         end
         nxt();
      end
      #1;
      checks++;
      if ({done, sout_vld, sout, busy} !== 4'b1001) begin
         errors++;
         $display("FAIL msb_done got done/vld/sout/busy=%b expected 1001", {done, sout_vld, sout, busy});
      end
      nxt();
      #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL msb_idle got done/busy=%b expected 00", {done, busy});
      end
      $display("msb: frame 1011 MSB-first on A complete");
   endtask

   task automatic test_lsb();
      logic [W-1:0] exp_bits;
      exp_bits = 4'b1101;
      req_b = 1'b1; data_b = 4'b1011; dir = 1'b1;
      #1;
      checks++;
      if ({gnt_a, gnt_b} !== 2'b01) begin
         errors++;
         $display("FAIL lsb_grant got %b expected 01", {gnt_a, gnt_b});
      end
      nxt();
      req_b = 1'b0; data_b = 4'h0;
      for (int i = 0; i < W; i++) begin
         if (i == 1) dir = 1'b0;
         if (i == 2) dir = 1'b1;
         if (i == 3) dir = 1'b0;
         #1;
         checks++;
         if ({sout_vld, sout, owner} !== {1'b1, exp_bits[W-1-i], 1'b1}) begin
            errors++;
            $display("FAIL lsb_bit%0d got vld/sout/owner=%b expected %b", i,
                     {sout_vld, sout, owner}, {1'b1, exp_bits[W-1-i], 1'b1});
         end
         nxt();
      end
      #1;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL lsb_done got %b expected 1", done);
      end
      nxt();
      $display("lsb: frame 1011 LSB-first on B complete");
   endtask

   task automatic test_contention();
      logic [W-1:0] word;
      logic         exp_b;
      req_a = 1'b1; req_b = 1'b1; data_a = 4'hA; data_b = 4'h5; dir = 1'b0;
      for (int f = 0; f < 3; f++) begin
         exp_b = (f == 1);
         word  = exp_b ? 4'h5 : 4'hA;
         #1;
         checks++;
         if ({gnt_a, gnt_b} !== {~exp_b, exp_b}) begin
            errors++;
            $display("FAIL cont_grant%0d got %b expected %b", f, {gnt_a, gnt_b}, {~exp_b, exp_b});
         end
         nxt();
         for (int i = 0; i < W; i++) begin
            #1;
            checks++;
            if ({sout_vld, sout, owner, gnt_a, gnt_b} !== {1'b1, word[W-1-i], exp_b, 2'b00}) begin
               errors++;
               $display("FAIL cont_f%0d_bit%0d got vld/sout/owner/gnts=%b expected %b", f, i,
                        {sout_vld, sout, owner, gnt_a, gnt_b}, {1'b1, word[W-1-i], exp_b, 2'b00});
            end
            nxt();
         end
         #1;
         checks++;
         if ({done, gnt_a, gnt_b} !== 3'b100) begin
            errors++;
            $display("FAIL cont_done%0d got done/gnts=%b expected 100", f, {done, gnt_a, gnt_b});
         end
         nxt();
         $display("contention: frame %0d owner=%0d word=%h", f, exp_b, word);
      end
      req_a = 1'b0; req_b = 1'b0;
      nxt();
   endtask

   task automatic test_reset_mid();
      req_a = 1'b1; data_a = 4'hF; dir = 1'b0;
      #1;
      checks++;
      if (gnt_a !== 1'b1) begin
         errors++;
         $display("FAIL midrst_grant got %b expected 1", gnt_a);
      end
      nxt();
      req_a = 1'b0;
      repeat (2) nxt();
      rst = 1'b0;
      #1;
      checks++;
      if ({sout_vld, sout, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL midrst_abort got vld/sout/busy/done=%b expected 0000", {sout_vld, sout, busy, done});
      end
      for (int i = 0; i < 3; i++) begin
         nxt();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone%0d got %b expected 0", i, done);
         end
      end
      req_a = 1'b1; req_b = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt_a, gnt_b, busy} !== 3'b100) begin
         errors++;
         $display("FAIL midrst_release got gnts/busy=%b expected 100", {gnt_a, gnt_b, busy});
      end
      nxt();
      req_a = 1'b0; req_b = 1'b0;
      repeat (6) nxt();
      $display("reset_mid: frame abandoned, A granted first after release");
   endtask

   task automatic test_late();
      logic saw_busy_grant;
      saw_busy_grant = 1'b0;
      req_a = 1'b1; data_a = 4'h3; dir = 1'b0;
      #1;
      checks++;
      if (gnt_a !== 1'b1) begin
         errors++;
         $display("FAIL late_grant_a got %b expected 1", gnt_a);
      end
      nxt();
      req_a = 1'b0;
      nxt();
      req_b = 1'b1; data_b = 4'h6;
      for (int i = 0; i < W; i++) begin
         #1;
         if (busy !== 1'b1 || gnt_b !== 1'b0) saw_busy_grant = 1'b1;
         nxt();
      end
      checks++;
      if (saw_busy_grant !== 1'b0) begin
         errors++;
         $display("FAIL late_busy_grant got 1 expected 0");
      end
      #1;
      checks++;
      if ({busy, gnt_b} !== 2'b01) begin
         errors++;
         $display("FAIL late_grant_b got busy/gnt_b=%b expected 01", {busy, gnt_b});
      end
      nxt();
      req_b = 1'b0;
      #1;
      checks++;
      if ({sout_vld, sout, owner} !== 3'b101) begin
         errors++;
         $display("FAIL late_b_bit0 got vld/sout/owner=%b expected 101", {sout_vld, sout, owner});
      end
      repeat (6) nxt();
      $display("late: B granted in IDLE after A's done");
   endtask

   initial begin
      test_reset();
      test_msb();
      test_lsb();
      test_contention();
      test_reset_mid();
      test_late();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_shift_ctrl
